// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: opcode/funct encodings, FSM state and ALU-op types for the
// multi-cycle MIPS core. Optional feature macro: MIPS_MC_JUMP_EN (j, jal, jr).
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

`ifdef MIPS_MC_JUMP_EN
  localparam logic JUMP_EN = 1'b1;
`else
  localparam logic JUMP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    STOP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  // True for every encoding the core can execute; jumps only when enabled.
  function automatic logic op_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
          FN_JR:   ok = JUMP_EN;
          default: ok = 1'b0;
        endcase
      end
      OP_J, OP_JAL: ok = JUMP_EN;
      OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW, OP_HALT: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // ALU operation for an instruction; I-type arithmetic and address generation add.
  function automatic alu_op_e alu_op_of(input logic [5:0] op, input logic [5:0] fn);
    alu_op_e r;
    r = ALU_ADD;
    if (op == OP_RTYPE) begin
      case (fn)
        FN_SUB:  r = ALU_SUB;
        FN_AND:  r = ALU_AND;
        FN_OR:   r = ALU_OR;
        FN_SLT:  r = ALU_SLT;
        default: r = ALU_ADD;
      endcase
    end else begin
      r = ALU_ADD;
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// mips_mc_regfile: 32 x DW register file, two async reads, one sync write,
// async clear. r0 is hard-wired to zero.
module mips_mc_regfile #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [4:0]    waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [4:0]    raddr_a_i,
  input  logic [4:0]    raddr_b_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] rf_q [32];

  // Register storage: cleared on reset, writes to r0 dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : rf_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : rf_q[raddr_b_i];

endmodule

// File: rtl/mips_mc_cpu.sv
// mips_mc_cpu: multi-cycle MIPS subset core with a single unified memory port.
// Optional feature macro: MIPS_MC_JUMP_EN (j, jal, jr; illegal when undefined).
module mips_mc_cpu
  import mips_mc_pkg::*;
#(
  parameter int            DW       = 32,
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [AW-1:0] pc_o,
  output logic          retire,
  output logic          halted,
  output logic          illegal
);

  state_e        state_q, state_d;
  alu_op_e       alu_op_q;
  logic [AW-1:0] pc_q, tgt_q;
  logic [31:0]   ir_q;
  logic [DW-1:0] a_q, b_q, alu_q;
  logic          go_q, illegal_q;

  logic [5:0]    op_s, fn_s;
  logic [4:0]    rs_s, rt_s, rd_s, waddr_s;
  logic [DW-1:0] imm_s, opb_s, alu_s, rd_a_s, rd_b_s, wdata_s;
  logic [AW-1:0] jmask_s, jtgt_s;
  logic          ack_s, legal_s, jump_s, jr_s, ctrl_s, take_s, rf_we_s;

  assign op_s    = ir_q[31:26];
  assign rs_s    = ir_q[25:21];
  assign rt_s    = ir_q[20:16];
  assign rd_s    = ir_q[15:11];
  assign fn_s    = ir_q[5:0];
  assign imm_s   = DW'($signed(ir_q[15:0]));
  assign legal_s = op_legal(op_s, fn_s);

  // go_q keeps the port quiet for the first cycle after reset so mem_req is 0 while in reset.
  assign mem_req   = go_q && ((state_q == FETCH) || (state_q == MEM));
  assign ack_s     = mem_req && mem_ack;
  assign mem_we    = (state_q == MEM) && (op_s == OP_SW);
  assign mem_addr  = (state_q == MEM) ? AW'(alu_q) : pc_q;
  assign mem_wdata = b_q;

  assign jump_s  = JUMP_EN && ((op_s == OP_J) || (op_s == OP_JAL));
  assign jr_s    = JUMP_EN && (op_s == OP_RTYPE) && (fn_s == FN_JR);
  assign take_s  = ((op_s == OP_BEQ) && (a_q == b_q)) || ((op_s == OP_BNE) && (a_q != b_q));
  assign ctrl_s  = (op_s == OP_BEQ) || (op_s == OP_BNE) || jump_s || jr_s;
  assign jmask_s = AW'(26'h3FF_FFFF);
  assign jtgt_s  = (pc_q & ~jmask_s) | (AW'(ir_q[25:0]) & jmask_s);

  assign rf_we_s = (state_q == WB) || ((state_q == EXEC) && JUMP_EN && (op_s == OP_JAL));
  assign waddr_s = (op_s == OP_JAL) ? 5'd31 : ((op_s == OP_RTYPE) ? rd_s : rt_s);
  assign wdata_s = (op_s == OP_JAL) ? DW'(pc_q) : alu_q;

  assign pc_o    = pc_q;
  assign halted  = (state_q == STOP);
  assign illegal = illegal_q;

  mips_mc_regfile #(.DW(DW)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (rf_we_s),
    .waddr_i   (waddr_s),
    .wdata_i   (wdata_s),
    .raddr_a_i (rs_s),
    .raddr_b_i (rt_s),
    .rdata_a_o (rd_a_s),
    .rdata_b_o (rd_b_s)
  );

  // ALU: second operand is B for R-type, the sign-extended immediate otherwise.
  always_comb begin
    opb_s = (op_s == OP_RTYPE) ? b_q : imm_s;
    case (alu_op_q)
      ALU_ADD: alu_s = a_q + opb_s;
      ALU_SUB: alu_s = a_q - opb_s;
      ALU_AND: alu_s = a_q & opb_s;
      ALU_OR:  alu_s = a_q | opb_s;
      ALU_SLT: alu_s = DW'($signed(a_q) < $signed(opb_s));
      default: alu_s = a_q + opb_s;
    endcase
  end

  // FSM next state and the retire pulse in each instruction's final cycle.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      FETCH: begin
        if (ack_s) state_d = DECODE;
        else       state_d = FETCH;
      end
      DECODE: begin
        if (!legal_s) begin
          state_d = STOP;
        end else if (op_s == OP_HALT) begin
          state_d = STOP;
          retire  = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (ctrl_s) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else if ((op_s == OP_LW) || (op_s == OP_SW)) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (ack_s && (op_s == OP_SW)) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else if (ack_s) begin
          state_d = WB;
        end else begin
          state_d = MEM;
        end
      end
      WB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      STOP:    state_d = STOP;
      default: state_d = STOP;
    endcase
  end

  // State register and datapath latches, updated per FSM phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0000_0000;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      tgt_q     <= '0;
      alu_op_q  <= ALU_ADD;
      go_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= 1'b1;
      case (state_q)
        FETCH: begin
          if (ack_s) begin
            ir_q <= 32'(mem_rdata);
            pc_q <= pc_q + AW'(1);
          end
        end
        DECODE: begin
          a_q      <= rd_a_s;
          b_q      <= rd_b_s;
          tgt_q    <= pc_q + AW'($signed(ir_q[15:0]));
          alu_op_q <= alu_op_of(op_s, fn_s);
          if (!legal_s) illegal_q <= 1'b1;
        end
        EXEC: begin
          alu_q <= alu_s;
          if (take_s)      pc_q <= tgt_q;
          else if (jump_s) pc_q <= jtgt_s;
          else if (jr_s)   pc_q <= AW'(a_q);
        end
        MEM: begin
          if (ack_s && (op_s == OP_LW)) alu_q <= mem_rdata;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_cpu.sv
// tb_mips_mc_cpu: directed-program bench for mips_mc_cpu with a wait-state memory model.
module tb_mips_mc_cpu;
  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          mem_req, mem_we, mem_ack, retire, halted, illegal;
  logic [AW-1:0] mem_addr, pc_o;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] prog [0:63];
  logic          ld_en = 1'b0;
  logic [7:0]    ld_addr = 8'd0;
  logic [DW-1:0] ld_data = '0;
  logic          force_ack = 1'b0;
  int            wait_cyc = 0;
  int            wcnt = 0;
  int            cyc = 0;
  int            ret_cnt = 0;
  int            ret_cyc [16];
  int            req_cyc = 0;
  int            wr_cnt = 0;

  always #5 clk = ~clk;

  mips_mc_cpu #(.DW(DW), .AW(AW), .RESET_PC(16'h0000)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .pc_o      (pc_o),
    .retire    (retire),
    .halted    (halted),
    .illegal   (illegal)
  );

  assign mem_ack   = force_ack || (mem_req && (wcnt >= wait_cyc));
  assign mem_rdata = mem[mem_addr[7:0]];

  // Memory model: program loading, store capture, wait-state counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_req && mem_ack && mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (!rst_n || !mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // Monitor: timestamp retire pulses and count request cycles.
  always @(negedge clk) begin
    if (retire) begin
      ret_cyc[ret_cnt % 16] = cyc;
      ret_cnt = ret_cnt + 1;
    end
    if (mem_req) req_cyc = req_cyc + 1;
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0000_0000;
  endtask

  // Hold reset, load prog[] into memory; reset stays asserted on return.
  task automatic boot(input int wc);
    rst_n = 1'b0;
    wait_cyc = wc;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      ld_en = 1'b1; ld_addr = 8'(i); ld_data = prog[i];
      @(negedge clk);
    end
    ld_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ret(input int target, input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (ret_cnt >= target) break;
    end
    ok = (ret_cnt >= target);
  endtask

  task automatic test_reset();
    bit ok;
    clear_prog();
    boot(0);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", mem_req); end
    checks++; if (pc_o !== 16'h0000) begin errors++; $display("FAIL rst_pc got %h want 0000", pc_o); end
    checks++; if ({retire, halted, illegal} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {retire, halted, illegal}); end
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (mem_req) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || mem_we !== 1'b0 || mem_addr !== 16'h0000) begin
      errors++; $display("FAIL rst_first_req got req=%b we=%b addr=%h want 1 0 0000", ok, mem_we, mem_addr);
    end
  endtask

  task automatic test_add();
    bit ok;
    int b;
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    prog[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    prog[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'd40);
    prog[4] = enc_i(6'h2B, 5'd0, 5'd2, 16'd41);
    boot(0);
    b = ret_cnt;
    rst_n = 1'b1;
    wait_ret(b + 5, 80, ok);
    repeat (3) @(posedge clk); #1;
    checks++; if (!ok) begin errors++; $display("FAIL add_retires got %0d want %0d", ret_cnt - b, 5); end
    checks++; if (ret_cyc[(b+1)%16] - ret_cyc[b%16] !== 4) begin errors++; $display("FAIL add_lat1 got %0d want 4", ret_cyc[(b+1)%16] - ret_cyc[b%16]); end
    checks++; if (ret_cyc[(b+2)%16] - ret_cyc[(b+1)%16] !== 4) begin errors++; $display("FAIL add_lat2 got %0d want 4", ret_cyc[(b+2)%16] - ret_cyc[(b+1)%16]); end
    checks++; if (mem[40] !== 32'h0000_0002) begin errors++; $display("FAIL add_r3 got %h want 00000002", mem[40]); end
    checks++; if (mem[41] !== 32'hFFFF_FFFD) begin errors++; $display("FAIL addi_neg got %h want fffffffd", mem[41]); end
    checks++; if (halted !== 1'b1 || illegal !== 1'b1) begin errors++; $display("FAIL illegal_stop got h=%b i=%b want 1 1", halted, illegal); end
  endtask

  task automatic test_alu_ops();
    bit ok;
    int b;
    clear_prog();
    prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd12);
    prog[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd10);
    prog[2]  = enc_i(6'h08, 5'd0, 5'd7, 16'hFFFF);
    prog[3]  = enc_r(5'd1, 5'd2, 5'd3, 6'h22);
    prog[4]  = enc_r(5'd1, 5'd2, 5'd4, 6'h24);
    prog[5]  = enc_r(5'd1, 5'd2, 5'd5, 6'h25);
    prog[6]  = enc_r(5'd7, 5'd1, 5'd6, 6'h2A);
    prog[7]  = enc_r(5'd1, 5'd7, 5'd8, 6'h2A);
    prog[8]  = enc_r(5'd7, 5'd7, 5'd9, 6'h20);
    prog[9]  = enc_i(6'h2B, 5'd0, 5'd3, 16'd40);
    prog[10] = enc_i(6'h2B, 5'd0, 5'd4, 16'd41);
    prog[11] = enc_i(6'h2B, 5'd0, 5'd5, 16'd42);
    prog[12] = enc_i(6'h2B, 5'd0, 5'd6, 16'd43);
    prog[13] = enc_i(6'h2B, 5'd0, 5'd8, 16'd44);
    prog[14] = enc_i(6'h2B, 5'd0, 5'd9, 16'd45);
    prog[15] = 32'hFC00_0000;
    for (int i = 40; i < 46; i++) prog[i] = 32'h5A5A_5A5A;
    boot(0);
    b = ret_cnt;
    rst_n = 1'b1;
    wait_ret(b + 16, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL alu_retires got %0d want 16", ret_cnt - b); end
    checks++; if (mem[40] !== 32'h0000_0002) begin errors++; $display("FAIL sub got %h want 00000002", mem[40]); end
    checks++; if (mem[41] !== 32'h0000_0008) begin errors++; $display("FAIL and got %h want 00000008", mem[41]); end
    checks++; if (mem[42] !== 32'h0000_000E) begin errors++; $display("FAIL or got %h want 0000000e", mem[42]); end
    checks++; if (mem[43] !== 32'h0000_0001) begin errors++; $display("FAIL slt_neg got %h want 00000001", mem[43]); end
    checks++; if (mem[44] !== 32'h0000_0000) begin errors++; $display("FAIL slt_pos got %h want 00000000", mem[44]); end
    checks++; if (mem[45] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL add_wrap got %h want fffffffe", mem[45]); end
  endtask

  task automatic test_mem_wait();
    bit ok;
    int b, w;
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    prog[2] = enc_i(6'h23, 5'd0, 5'd4, 16'd8);
    prog[3] = enc_i(6'h2B, 5'd0, 5'd4, 16'd9);
    boot(3);
    b = ret_cnt;
    w = wr_cnt;
    rst_n = 1'b1;
    wait_ret(b + 4, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mem_retires got %0d want 4", ret_cnt - b); end
    checks++; if (mem[8] !== 32'h0000_0005) begin errors++; $display("FAIL sw_data got %h want 00000005", mem[8]); end
    checks++; if (mem[9] !== 32'h0000_0005) begin errors++; $display("FAIL lw_r4 got %h want 00000005", mem[9]); end
    checks++; if (wr_cnt - w !== 2) begin errors++; $display("FAIL wr_count got %0d want 2", wr_cnt - w); end
    checks++; if (ret_cyc[(b+1)%16] - ret_cyc[b%16] !== 10) begin errors++; $display("FAIL sw_lat got %0d want 10", ret_cyc[(b+1)%16] - ret_cyc[b%16]); end
    checks++; if (ret_cyc[(b+2)%16] - ret_cyc[(b+1)%16] !== 11) begin errors++; $display("FAIL lw_lat got %0d want 11", ret_cyc[(b+2)%16] - ret_cyc[(b+1)%16]); end
  endtask

  task automatic test_branch();
    bit ok;
    int b;
    clear_prog();
    for (int i = 0; i < 4; i++) prog[i] = enc_i(6'h08, 5'd0, 5'd0, 16'd0);
    prog[4] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    boot(0);
    b = ret_cnt;
    rst_n = 1'b1;
    wait_ret(b + 7, 80, ok);
    checks++; if (!ok || pc_o !== 16'h0004) begin errors++; $display("FAIL beq_loop_pc got %h want 0004", pc_o); end
    checks++; if (ret_cyc[(b+6)%16] - ret_cyc[(b+5)%16] !== 3) begin errors++; $display("FAIL beq_lat got %0d want 3", ret_cyc[(b+6)%16] - ret_cyc[(b+5)%16]); end
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    prog[1] = enc_i(6'h05, 5'd1, 5'd0, 16'd2);
    prog[4] = enc_i(6'h05, 5'd0, 5'd0, 16'd7);
    prog[5] = 32'hFC00_0000;
    boot(0);
    b = ret_cnt;
    rst_n = 1'b1;
    wait_ret(b + 3, 60, ok);
    checks++; if (!ok || pc_o !== 16'h0005) begin errors++; $display("FAIL bne_fall_pc got %h want 0005", pc_o); end
    checks++; if (ret_cyc[(b+1)%16] - ret_cyc[b%16] !== 3) begin errors++; $display("FAIL bne_taken_lat got %0d want 3", ret_cyc[(b+1)%16] - ret_cyc[b%16]); end
    wait_ret(b + 4, 20, ok);
    repeat (2) @(posedge clk); #1;
    checks++; if (!ok || halted !== 1'b1 || illegal !== 1'b0 || pc_o !== 16'h0006) begin
      errors++; $display("FAIL halt_after_bne got h=%b i=%b pc=%h want 1 0 0006", halted, illegal, pc_o);
    end
  endtask

  task automatic test_jump();
    bit ok;
    int b, r;
    clear_prog();
    for (int i = 0; i < 3; i++) prog[i] = enc_i(6'h08, 5'd0, 5'd0, 16'd0);
    prog[3]  = {6'h03, 26'h000_0020};
    prog[32] = enc_i(6'h2B, 5'd0, 5'd31, 16'd50);
    prog[33] = 32'hFC00_0000;
    prog[50] = 32'h5A5A_5A5A;
    boot(0);
    b = ret_cnt;
    rst_n = 1'b1;
`ifdef MIPS_MC_JUMP_EN
    wait_ret(b + 6, 100, ok);
    repeat (2) @(posedge clk); #1;
    checks++; if (!ok) begin errors++; $display("FAIL jal_retires got %0d want 6", ret_cnt - b); end
    checks++; if (mem[50] !== 32'h0000_0004) begin errors++; $display("FAIL jal_r31 got %h want 00000004", mem[50]); end
    checks++; if (ret_cyc[(b+3)%16] - ret_cyc[(b+2)%16] !== 3) begin errors++; $display("FAIL jal_lat got %0d want 3", ret_cyc[(b+3)%16] - ret_cyc[(b+2)%16]); end
    checks++; if (halted !== 1'b1 || illegal !== 1'b0 || pc_o !== 16'h0022) begin errors++; $display("FAIL jal_end got h=%b i=%b pc=%h want 1 0 0022", halted, illegal, pc_o); end
`else
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (halted) begin ok = 1'b1; break; end
    end
    r = req_cyc;
    repeat (10) @(posedge clk); #1;
    checks++; if (!ok || illegal !== 1'b1) begin errors++; $display("FAIL jal_illegal got h=%b i=%b want 1 1", halted, illegal); end
    checks++; if (ret_cnt - b !== 3) begin errors++; $display("FAIL jal_noretire got %0d want 3", ret_cnt - b); end
    checks++; if (req_cyc !== r || mem_req !== 1'b0) begin errors++; $display("FAIL jal_quiet got %0d req cycles want 0", req_cyc - r); end
    checks++; if (pc_o !== 16'h0004) begin errors++; $display("FAIL jal_pc got %h want 0004", pc_o); end
`endif
  endtask

  task automatic test_reset_mid_mem();
    bit ok;
    int w;
    clear_prog();
    prog[0]  = enc_i(6'h2B, 5'd0, 5'd0, 16'd30);
    prog[30] = 32'h1234_5678;
    boot(5);
    w = wr_cnt;
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (mem_req && mem_we) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || mem_addr !== 16'd30) begin errors++; $display("FAIL mid_mem_reach got ok=%b addr=%h want 1 001e", ok, mem_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || pc_o !== 16'h0000) begin errors++; $display("FAIL mid_rst_drop got req=%b pc=%h want 0 0000", mem_req, pc_o); end
    repeat (2) @(negedge clk);
    checks++; if (wr_cnt !== w || mem[30] !== 32'h1234_5678) begin errors++; $display("FAIL mid_rst_nowrite got %h want 12345678", mem[30]); end
    wait_cyc = 0;
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (mem_req) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || mem_we !== 1'b0 || mem_addr !== 16'h0000) begin
      errors++; $display("FAIL mid_rst_refetch got req=%b we=%b addr=%h want 1 0 0000", ok, mem_we, mem_addr);
    end
  endtask

  task automatic test_halt_r0();
    bit ok;
    int b, r;
    clear_prog();
    prog[0]  = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    prog[1]  = enc_i(6'h2B, 5'd0, 5'd0, 16'd20);
    prog[2]  = 32'hFC00_0000;
    prog[20] = 32'hDEAD_BEEF;
    boot(0);
    b = ret_cnt;
    rst_n = 1'b1;
    wait_ret(b + 3, 60, ok);
    repeat (2) @(posedge clk); #1;
    checks++; if (!ok || mem[20] !== 32'h0000_0000) begin errors++; $display("FAIL r0_zero got %h want 00000000", mem[20]); end
    checks++; if (halted !== 1'b1 || illegal !== 1'b0) begin errors++; $display("FAIL halt_flags got h=%b i=%b want 1 0", halted, illegal); end
    r = req_cyc;
    force_ack = 1'b1;
    repeat (5) @(posedge clk);
    force_ack = 1'b0;
    repeat (5) @(posedge clk); #1;
    checks++; if (req_cyc !== r || mem_req !== 1'b0) begin errors++; $display("FAIL stop_quiet got %0d req cycles want 0", req_cyc - r); end
    checks++; if (ret_cnt - b !== 3 || pc_o !== 16'h0003 || halted !== 1'b1) begin
      errors++; $display("FAIL stop_absorb got ret=%0d pc=%h h=%b want 3 0003 1", ret_cnt - b, pc_o, halted);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_mem_wait();
    test_branch();
    test_jump();
    test_reset_mid_mem();
    test_halt_r0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_cpu.md
MIPS_MC_CPU -- requirements
Module: mips_mc_cpu

Interface
REQ-001 SHALL have parameter DW, default 32, meaning datapath/register width (legal 16..64).
REQ-002 SHALL have parameter AW, default 16, meaning word-address width of PC and memory port.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC value loaded at reset.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mem_req  out  1  memory request, held until accepted.
REQ-007 SHALL have port mem_we  out  1  1=write, 0=read; stable while mem_req.
REQ-008 SHALL have port mem_addr  out  AW  word address; stable while mem_req.
REQ-009 SHALL have port mem_wdata  out  DW  store data; stable while mem_req.
REQ-010 SHALL have port mem_rdata  in  DW  read data, valid in the mem_ack cycle.
REQ-011 SHALL have port mem_ack  in  1  accept/complete; sampled only while mem_req=1.
REQ-012 SHALL have port pc_o  out  AW  current PC.
REQ-013 SHALL have port retire  out  1  one-cycle pulse per completed instruction.
REQ-014 SHALL have port halted  out  1  core stopped (HALT or illegal opcode).
REQ-015 SHALL have port illegal  out  1  sticky; stop caused by an unsupported encoding.

Function
REQ-016 SHALL be a multi-cycle core with one unified memory port for both fetch and data.
REQ-017 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, STOP.
REQ-018 FETCH SHALL assert mem_req with mem_we=0 and mem_addr=PC; on mem_ack it SHALL latch IR, set PC=PC+1 and go to DECODE. A zero-wait ack completes FETCH in 1 cycle.
REQ-019 DECODE SHALL latch A=rf[rs], B=rf[rt] and target=PC+sext(imm); it SHALL go to STOP with illegal=1 on an unsupported opcode or funct.
REQ-020 EXEC SHALL compute the ALU result; beq/bne/j/jal/jr SHALL complete in EXEC.
REQ-021 R-type add/sub/and/or/slt and addi SHALL go from EXEC to WB.
REQ-022 lw/sw SHALL go EXEC->MEM with addr=(A+sext(imm))[AW-1:0]; sw data SHALL be B.
REQ-023 MEM SHALL hold the request until mem_ack; lw SHALL go to WB; sw SHALL retire and go to FETCH.
REQ-024 PC and branch offsets SHALL be word units; branch target SHALL be PC+1+sext(imm) with no shift; PC SHALL wrap modulo 2^AW.
REQ-025 Arithmetic SHALL be modulo 2^DW; slt SHALL be signed; immediates SHALL be sign-extended to DW.
REQ-026 Writes to r0 SHALL be discarded; r0 SHALL always read as 0.
REQ-027 Latency with zero-wait memory SHALL be: R-type/addi 4, lw 5, sw 4, beq/bne/j/jal/jr 3 cycles.
REQ-028 retire SHALL pulse in the final cycle of each instruction and never in STOP.
REQ-029 Opcode 6'h3F SHALL be HALT: it SHALL retire, enter STOP with halted=1 and illegal=0.
REQ-030 STOP SHALL be absorbing until reset, with mem_req=0.
REQ-031 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL immediately force: PC=RESET_PC, state=FETCH, mem_req=0, retire=0, halted=0, illegal=0.
REQ-033 Reset asserted during an outstanding request SHALL abandon it; the first post-reset request SHALL be a fetch at RESET_PC.
REQ-034 Register file contents SHALL be cleared to 0 at reset.

Configuration
REQ-035 Macro MIPS_MC_JUMP_EN SHALL gate j (0x02), jal (0x03) and jr (R-type funct 0x08).
REQ-036 With MIPS_MC_JUMP_EN defined: j sets PC={PC[AW-1:26 or none], IR[25:0]} truncated to AW; jal also writes old PC (already +1) to r31; jr sets PC=A[AW-1:0].
REQ-037 Without MIPS_MC_JUMP_EN: these encodings SHALL be illegal (REQ-019).

Structure
REQ-038 Package mips_mc_pkg SHALL hold opcode/funct constants, the FSM state enum and ALU-op encoding.
REQ-039 The register file SHALL be a sub-module mips_mc_regfile: 2 async reads, 1 sync write, async clear.

Verification
REQ-040 addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2 with zero-wait memory -> r3=2, three retire pulses 4 cycles apart.
REQ-041 sw r1,8(r0) then lw r4,8(r0) with mem_ack delayed 3 cycles -> write at addr 8 with data 5, r4=5, lw takes 5+3+3 cycles.
REQ-042 beq r0,r0,-1 at PC 4 -> PC returns to 4 every 3 cycles; bne r0,r0 -> falls through to PC 5.
REQ-043 jal 0x20 at PC 3, macro defined -> PC=0x20, r31=4; macro undefined -> halted=1, illegal=1, mem_req stays 0.
REQ-044 rst_n low mid-MEM with mem_req high -> mem_req drops at once; after release, first request is a read at RESET_PC.
REQ-045 addi r0,r0,7 then HALT -> r0 reads 0, halted=1, illegal=0, no further requests.
